// File: rtl/jtframe_credits_pkg.sv
// jtframe_credits_pkg: state encoding and default frame counts for the credits sequencer
package jtframe_credits_pkg;
  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_BOOT   = 3'd1,
    ST_SHOW   = 3'd2,
    ST_HIDDEN = 3'd3,
    ST_UNHIDE = 3'd4
  } state_t;
  localparam int DEF_HOLD_FRAMES    = 30;
  localparam int DEF_TIMEOUT_FRAMES = 1800;
endpackage

// File: rtl/jtframe_credits_btn.sv
// jtframe_credits_btn: button synchroniser, frame-rate debounce, press edge and hold counter
module jtframe_credits_btn
  import jtframe_credits_pkg::*;
#(
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic press,
  output logic held
);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_FRAMES);
  logic [1:0]    r_sync;
  logic          r_smp;
  logic [HW-1:0] r_hold;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_smp  <= 1'b0;
      r_hold <= '0;
    end else begin
      r_sync <= {r_sync[0], btn};
      if (tick) begin
        r_smp  <= r_sync[1];
        r_hold <= !r_sync[1] ? '0 : r_hold == HMAX ? r_hold : r_hold + 1'b1;
      end
    end
  end
  // press is decided combinationally on the tick so the FSM reacts on that same edge
  assign press = tick & r_sync[1] & ~r_smp;
  assign held  = r_hold == HMAX;
endmodule

// File: rtl/jtframe_credits_ctrl.sv
// jtframe_credits_ctrl: credits overlay sequencer (enable/toggle/fast_scroll)
// Auto-hide timeout is built only when JTFRAME_CREDITS_AUTOHIDE_EN is defined.
module jtframe_credits_ctrl
  import jtframe_credits_pkg::*;
#(
  parameter int BLKPOL         = 1,
  parameter int SHOW_AT_BOOT   = 1,
  parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES,
  parameter int HOLD_FRAMES    = DEF_HOLD_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       VB,
  input  logic       pause,
  input  logic       btn,
  output logic       enable,
  output logic       toggle,
  output logic       fast_scroll,
  output logic [2:0] st_dbg
);
  localparam int FW = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [FW-1:0] FMAX = FW'(TIMEOUT_FRAMES);
  state_t        r_st, w_nxt;
  logic          r_vb, r_pause, r_booted, r_en, r_tog, r_fast;
  logic [FW-1:0] r_frames;
  logic          w_vb, w_tick, w_prise, w_press, w_held, w_timeout, w_tog;
  assign w_vb    = BLKPOL != 0 ? VB : ~VB;
  assign w_tick  = w_vb & ~r_vb;
  assign w_prise = pause & ~r_pause;
`ifdef JTFRAME_CREDITS_AUTOHIDE_EN
  localparam logic [FW-1:0] FLAST = FW'(TIMEOUT_FRAMES - 1);
  assign w_timeout = w_tick && r_frames == FLAST;
`else
  assign w_timeout = 1'b0;
`endif
  jtframe_credits_btn #(.HOLD_FRAMES(HOLD_FRAMES)) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick),
    .btn   (btn),
    .press (w_press),
    .held  (w_held)
  );
  // pause low is treated as a level in SHOW/HIDDEN; UNHIDE waits a cycle after a toggle pulse
  always_comb begin
    w_nxt = r_st;
    w_tog = 1'b0;
    case (r_st)
      ST_OFF:    w_nxt = (!r_booted && SHOW_AT_BOOT != 0) ? ST_BOOT : w_prise ? ST_SHOW : ST_OFF;
      ST_BOOT:   w_nxt = (w_timeout || w_press) ? ST_OFF : ST_BOOT;
      ST_SHOW: begin
        w_nxt = !pause ? ST_OFF : (w_timeout || w_press) ? ST_HIDDEN : ST_SHOW;
        w_tog = pause && (w_timeout || w_press);
      end
      ST_HIDDEN: begin
        w_nxt = !pause ? (r_tog ? ST_HIDDEN : ST_UNHIDE) : w_press ? ST_SHOW : ST_HIDDEN;
        w_tog = !pause ? !r_tog : w_press;
      end
      ST_UNHIDE: w_nxt = ST_OFF;
      default:   w_nxt = ST_OFF;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st     <= ST_OFF;
      r_vb     <= 1'b0;
      r_pause  <= 1'b0;
      r_booted <= 1'b0;
      r_en     <= 1'b0;
      r_tog    <= 1'b0;
      r_fast   <= 1'b0;
      r_frames <= '0;
    end else begin
      r_st     <= w_nxt;
      r_vb     <= w_vb;
      r_pause  <= pause;
      r_booted <= 1'b1;
      r_en     <= w_nxt != ST_OFF;
      r_tog    <= w_tog;
      r_fast   <= r_st == ST_SHOW && w_nxt == ST_SHOW && w_held;
      r_frames <= w_nxt != r_st ? '0 : (w_tick && r_frames != FMAX) ? r_frames + 1'b1 : r_frames;
    end
  end
  assign enable      = r_en;
  assign toggle      = r_tog;
  assign fast_scroll = r_fast;
  assign st_dbg      = r_st;
endmodule

// File: tb/tb_jtframe_credits_ctrl.sv
// tb_jtframe_credits_ctrl: scoreboard bench; expected toggle states queued at stimulus, popped on each pulse
module tb_jtframe_credits_ctrl;
  localparam int TO = 4;
  logic       clk = 1'b0, rst_n = 1'b0, VB = 1'b0, pause = 1'b0, btn = 1'b0;
  logic       enable, toggle, fast_scroll, hide;
  logic [2:0] st_dbg;
  int         n_chk = 0, n_fail = 0, vcnt = 0;
  int         sb[$];
  jtframe_credits_ctrl #(
    .BLKPOL(1), .SHOW_AT_BOOT(1), .TIMEOUT_FRAMES(TO), .HOLD_FRAMES(30)
  ) dut (
    .clk(clk), .rst_n(rst_n), .VB(VB), .pause(pause), .btn(btn),
    .enable(enable), .toggle(toggle), .fast_scroll(fast_scroll), .st_dbg(st_dbg)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    vcnt <= vcnt == 7 ? 0 : vcnt + 1;
    VB   <= vcnt >= 5 && vcnt <= 6;
  end
  always @(posedge clk) hide <= !rst_n ? 1'b0 : hide ^ toggle;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (rst_n && toggle) begin
    check("tog_pending", sb.size() > 0 ? 1 : 0, 1);
    if (sb.size() > 0) check("tog_state", int'(st_dbg), sb.pop_front());
    check("tog_enable", int'(enable), 1);
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic btn_set(input logic v);
    @(negedge VB);
    @(negedge clk);
    btn = v;
  endtask
  task automatic settle_tick();
    @(posedge VB);
    repeat (3) @(negedge clk);
  endtask
  task automatic press();
    btn_set(1'b1);
    settle_tick();
    btn_set(1'b0);
    settle_tick();
  endtask
  task automatic set_pause(input logic v);
    @(negedge VB);
    @(negedge clk);
    pause = v;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    repeat (4) @(negedge clk);
    check("rst_en", int'(enable), 0);
    check("rst_tog", int'(toggle), 0);
    check("rst_fast", int'(fast_scroll), 0);
    check("rst_st", int'(st_dbg), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("boot_en", int'(enable), 1);
    check("boot_st", int'(st_dbg), 1);
    repeat (3) @(posedge VB);
    press();
    check("boot_off_st", int'(st_dbg), 0);
    check("boot_off_en", int'(enable), 0);
    set_pause(1'b1);
    check("show_en", int'(enable), 1);
    check("show_st", int'(st_dbg), 2);
    sb.push_back(3);
    press();
    check("press1_st", int'(st_dbg), 3);
    sb.push_back(2);
    press();
    check("press2_st", int'(st_dbg), 2);
    sb.push_back(3);
    press();
    check("press3_st", int'(st_dbg), 3);
    check("hidden_fast", int'(fast_scroll), 0);
    @(negedge clk);
    pause = 1'b0;
    sb.push_back(4);
    @(negedge clk);
    check("unhide_tog", int'(toggle), 1);
    check("unhide_en", int'(enable), 1);
    check("unhide_st", int'(st_dbg), 4);
    @(negedge clk);
    check("unhide_tog_end", int'(toggle), 0);
    check("unhide_en_end", int'(enable), 0);
    check("unhide_st_end", int'(st_dbg), 0);
    set_pause(1'b1);
    check("repause_st", int'(st_dbg), 2);
    check("repause_hide", int'(hide), 0);
    sb.push_back(3);
    press();
    sb.push_back(2);
    btn_set(1'b1);
    repeat (29) @(posedge VB);
    repeat (3) @(negedge clk);
    check("hold29_fast", int'(fast_scroll), 0);
    check("hold29_st", int'(st_dbg), 2);
    @(posedge VB);
    repeat (3) @(negedge clk);
    check("hold30_fast", int'(fast_scroll), 1);
    repeat (5) @(posedge VB);
    repeat (3) @(negedge clk);
    check("hold35_fast", int'(fast_scroll), 1);
    btn_set(1'b0);
    @(posedge VB);
    repeat (3) @(negedge clk);
    check("rel_fast", int'(fast_scroll), 0);
    check("rel_st", int'(st_dbg), 2);
    set_pause(1'b0);
    check("pfall_st", int'(st_dbg), 0);
    set_pause(1'b1);
    check("reshow_st", int'(st_dbg), 2);
`ifdef JTFRAME_CREDITS_AUTOHIDE_EN
    sb.push_back(3);
    repeat (TO - 1) @(posedge VB);
    repeat (3) @(negedge clk);
    check("to_pre_st", int'(st_dbg), 2);
    @(posedge VB);
    repeat (3) @(negedge clk);
    check("to_st", int'(st_dbg), 3);
    sb.push_back(2);
    press();
`else
    repeat (100) @(posedge VB);
    repeat (3) @(negedge clk);
    check("noto_st", int'(st_dbg), 2);
    check("noto_en", int'(enable), 1);
`endif
    btn_set(1'b1);
    @(posedge VB);
    @(negedge clk);
    pause = 1'b0;
    repeat (2) @(negedge clk);
    check("coll_st", int'(st_dbg), 0);
    check("coll_en", int'(enable), 0);
    btn_set(1'b0);
    settle_tick();
    set_pause(1'b1);
    check("mid_st", int'(st_dbg), 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_en", int'(enable), 0);
    check("mid_rst_st", int'(st_dbg), 0);
    check("mid_rst_fast", int'(fast_scroll), 0);
    pause = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reboot_st", int'(st_dbg), 1);
    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jtframe_credits_ctrl.md
# jtframe_credits_ctrl

Sequencer for the credits/pause overlay. It turns the core's pause request and a single user button into the `enable`, `toggle` and `fast_scroll` controls that the credits overlay consumes. It counts video frames, optionally shows the credits at boot, hides the overlay after a timeout, and keeps the overlay's internal hide flag consistent across pause cycles. It sits between the core's input/pause logic and the credits overlay, in the same pixel clock domain.

## Interface
Parameters:
- `BLKPOL`, 1: polarity of `VB` (1 = active high).
- `SHOW_AT_BOOT`, 1: show credits once after reset, independent of `pause`.
- `TIMEOUT_FRAMES`, 1800: frames before auto-hide (only with the macro).
- `HOLD_FRAMES`, 30: frames the button must be held to assert `fast_scroll`.

Ports:
- `clk`, in, 1: system clock. One clock; reset is synchronous and active-low.
- `rst_n`, in, 1: synchronous active-low reset.
- `VB`, in, 1: vertical blank, polarity set by `BLKPOL`.
- `pause`, in, 1: core pause request; level.
- `btn`, in, 1: user button, active high, asynchronous.
- `enable`, out, 1: to overlay `enable`.
- `toggle`, out, 1: to overlay `toggle`; single-cycle pulses.
- `fast_scroll`, out, 1: to overlay `fast_scroll`.
- `st_dbg`, out, 3: current state encoding.

## Operation
- `vb = BLKPOL ? VB : ~VB`. A frame tick is one `clk` cycle on the `vb` rising edge.
- `btn` passes through a 2-flop synchroniser and is then sampled only on frame ticks, which debounces it.
- A press is a sampled 1 whose previous sample was 0.
- The hold counter counts consecutive sampled-1 frames and saturates at `HOLD_FRAMES`.
- The frame counter is `$clog2(TIMEOUT_FRAMES+1)` bits, saturating. It clears on every state entry and increments on each frame tick.
- States are OFF(0), BOOT(1), SHOW(2), HIDDEN(3) and UNHIDE(4).
- OFF drives `enable`=0.
  - `pause` rising edge → SHOW.
- BOOT drives `enable`=1.
  - Press → OFF.
  - Timeout (macro) → OFF.
  - `pause` is ignored.
- SHOW drives `enable`=1. `fast_scroll`=1 while the hold counter equals `HOLD_FRAMES`.
  - Press, decided on the tick where the sample goes 0→1 → HIDDEN, with a `toggle` pulse.
  - Timeout (macro) → HIDDEN, with a `toggle` pulse.
  - `pause` falls → OFF.
- HIDDEN drives `enable`=1 and `fast_scroll`=0.
  - Press → SHOW, with a `toggle` pulse.
  - `pause` falls → UNHIDE.
- UNHIDE holds `enable`=1, pulses `toggle` for one cycle, then → OFF. This leaves the overlay's hide flag cleared, so the next `enable` rise shows credits.
- Priority within one cycle: `pause` fall > timeout > press.

## Timing
- All outputs are registered. Reset values: `enable`=0, `toggle`=0, `fast_scroll`=0, `st_dbg`=0 (OFF).
- On the first cycle after `rst_n` rises with `SHOW_AT_BOOT`=1, the state becomes BOOT and `enable`=1 on the following cycle.
- `toggle` is exactly one cycle wide. Consecutive pulses are at least one frame apart; UNHIDE is at least 2 cycles after any earlier pulse.
- Press latency: the `btn` edge reaches the sampler after 2 cycles, then waits for the next frame tick. `toggle`/state update one cycle after that tick.
- `pause` falling in HIDDEN: `toggle` is high in the UNHIDE cycle and `enable` falls the cycle after.
- The timeout fires on the tick where the counter reaches `TIMEOUT_FRAMES`.
- `fast_scroll` clears one cycle after the tick sampling `btn`=0, and on leaving SHOW.
- If `rst_n` goes low mid-operation, all outputs return to reset values next cycle. The overlay must be reset by the same system reset.

## Configuration
- `JTFRAME_CREDITS_AUTOHIDE_EN` defined: timeout transitions in BOOT and SHOW are active.
- Undefined: no timeout. Credits stay until a press or `pause` change, and the frame counter is still present for `st_dbg`-free builds but unused.

## Structure
- Package `jtframe_credits_pkg` holds the state encoding constants (OFF..UNHIDE) and the default `HOLD_FRAMES`/`TIMEOUT_FRAMES`.
- Sub-module `jtframe_credits_btn` contains the synchroniser, frame-rate sampling, press detection and hold counter. Its outputs are `press` and `held`.

## Test plan
- Reset with `SHOW_AT_BOOT`=1, `pause`=0 → `enable`=1 within 2 cycles of `rst_n` rising. A press 3 frames later → `enable`=0 and no `toggle`.
- `pause` 0→1 from OFF → `enable`=1 and `st_dbg`=2. A press → one `toggle` pulse and `st_dbg`=3. A second press → `toggle` pulse and `st_dbg`=2.
- In HIDDEN, `pause` 1→0 → `toggle`=1 for exactly one cycle while `enable`=1, then `enable`=0. Re-pausing → SHOW, and a model of the overlay's hide flag reads 0.
- In SHOW, hold `btn` for 35 frames with `HOLD_FRAMES`=30 → `fast_scroll` rises on the 30th tick. Release → it falls one cycle after the next tick, with no state change.
- With the macro and `TIMEOUT_FRAMES`=4 → HIDDEN plus a `toggle` pulse on the 4th tick after entering SHOW. Without the macro, SHOW persists for 100 frames.
- `pause` falls on the same tick as a press in SHOW → OFF, and no `toggle` is issued.
